// File: rtl/lamp_conflict_monitor.sv
// ----------------------------------------------------------------------------
// lamp_conflict_monitor
// Safety stage between the light controller and the lamp drivers: passes legal
// lamp patterns, holds through illegal ones, latches a flashing-yellow fault.
// Optional dark (000) detection: define LAMP_MON_DARK_DET_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lamp_conflict_monitor #(
  parameter int INIT_CYCLES  = 4,
  parameter int FAULT_CYCLES = 3,
  parameter int FLASH_HALF   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red_in,
  input  logic       yellow_in,
  input  logic       green_in,
  input  logic       fault_clear,
  output logic       red_out,
  output logic       yellow_out,
  output logic       green_out,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_NORMAL = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [3:0] INIT_LAST  = 4'(INIT_CYCLES - 1);
  localparam logic [3:0] FAULT_LIM  = 4'(FAULT_CYCLES);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_HALF - 1);

  localparam logic [2:0] PAT_RED    = 3'b100;
  localparam logic [2:0] PAT_YELLOW = 3'b010;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_CONFLICT = 2'b01;
`ifdef LAMP_MON_DARK_DET_EN
  localparam logic [1:0] CODE_DARK     = 2'b10;
`endif

  state_t     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic [3:0] conf_cnt_q, conf_cnt_d;
  logic [3:0] flash_cnt_q, flash_cnt_d;
  logic       phase_q, phase_d;
  logic [2:0] last_q, last_d;
  logic [2:0] out_q, out_d;
  logic       fault_q, fault_d;
  logic [1:0] code_q, code_d;
`ifdef LAMP_MON_DARK_DET_EN
  logic [3:0] dark_cnt_q, dark_cnt_d;
`endif

  logic [2:0] pat_in;
  logic       is_conflict;
  logic       is_legal;

  assign pat_in      = {red_in, yellow_in, green_in};
  assign is_conflict = green_in & (red_in | yellow_in);
`ifdef LAMP_MON_DARK_DET_EN
  assign is_legal    = !is_conflict && (pat_in != 3'b000);
`else
  assign is_legal    = !is_conflict;
`endif

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    conf_cnt_d  = conf_cnt_q;
    flash_cnt_d = flash_cnt_q;
    phase_d     = phase_q;
    last_d      = last_q;
    out_d       = out_q;
    fault_d     = fault_q;
    code_d      = code_q;
`ifdef LAMP_MON_DARK_DET_EN
    dark_cnt_d  = dark_cnt_q;
`endif

    case (state_q)
      ST_INIT: begin
        out_d      = PAT_RED;
        conf_cnt_d = 4'd0;
`ifdef LAMP_MON_DARK_DET_EN
        dark_cnt_d = 4'd0;
`endif
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_NORMAL;
          init_cnt_d = 4'd0;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end

      ST_NORMAL: begin
        if (is_legal) begin
          out_d      = pat_in;
          last_d     = pat_in;
          conf_cnt_d = 4'd0;
`ifdef LAMP_MON_DARK_DET_EN
          dark_cnt_d = 4'd0;
`endif
        end else if (is_conflict) begin
          out_d      = last_q;
          conf_cnt_d = (conf_cnt_q == FAULT_LIM) ? conf_cnt_q : conf_cnt_q + 4'd1;
`ifdef LAMP_MON_DARK_DET_EN
          dark_cnt_d = 4'd0;
`endif
          if (conf_cnt_d == FAULT_LIM) begin
            state_d     = ST_FAULT;
            fault_d     = 1'b1;
            code_d      = CODE_CONFLICT;
            phase_d     = 1'b1;
            flash_cnt_d = 4'd0;
            out_d       = PAT_YELLOW;
          end
        end
`ifdef LAMP_MON_DARK_DET_EN
        else begin
          out_d      = last_q;
          conf_cnt_d = 4'd0;
          dark_cnt_d = (dark_cnt_q == FAULT_LIM) ? dark_cnt_q : dark_cnt_q + 4'd1;
          if (dark_cnt_d == FAULT_LIM) begin
            state_d     = ST_FAULT;
            fault_d     = 1'b1;
            code_d      = CODE_DARK;
            phase_d     = 1'b1;
            flash_cnt_d = 4'd0;
            out_d       = PAT_YELLOW;
          end
        end
`endif
      end

      ST_FAULT: begin
        // Clearing requires a sane controller pattern on the same edge.
        if (fault_clear && is_legal) begin
          state_d     = ST_INIT;
          init_cnt_d  = 4'd0;
          conf_cnt_d  = 4'd0;
          flash_cnt_d = 4'd0;
          phase_d     = 1'b0;
          last_d      = PAT_RED;
          out_d       = PAT_RED;
          fault_d     = 1'b0;
          code_d      = CODE_NONE;
`ifdef LAMP_MON_DARK_DET_EN
          dark_cnt_d  = 4'd0;
`endif
        end else begin
          if (flash_cnt_q == FLASH_LAST) begin
            phase_d     = ~phase_q;
            flash_cnt_d = 4'd0;
          end else begin
            flash_cnt_d = flash_cnt_q + 4'd1;
          end
          out_d = {1'b0, phase_d, 1'b0};
        end
      end

      default: begin
        state_d    = ST_INIT;
        init_cnt_d = 4'd0;
        out_d      = PAT_RED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= 4'd0;
      conf_cnt_q  <= 4'd0;
      flash_cnt_q <= 4'd0;
      phase_q     <= 1'b0;
      last_q      <= PAT_RED;
      out_q       <= PAT_RED;
      fault_q     <= 1'b0;
      code_q      <= CODE_NONE;
`ifdef LAMP_MON_DARK_DET_EN
      dark_cnt_q  <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      conf_cnt_q  <= conf_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      phase_q     <= phase_d;
      last_q      <= last_d;
      out_q       <= out_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
`ifdef LAMP_MON_DARK_DET_EN
      dark_cnt_q  <= dark_cnt_d;
`endif
    end
  end

  assign red_out    = out_q[2];
  assign yellow_out = out_q[1];
  assign green_out  = out_q[0];
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

`default_nettype wire

// File: tb/tb_lamp_conflict_monitor.sv
// ----------------------------------------------------------------------------
// tb_lamp_conflict_monitor
// Table vectors, hand sequences and random stimulus against a behavioural model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lamp_conflict_monitor;

  localparam int INIT_CYCLES  = 4;
  localparam int FAULT_CYCLES = 3;
  localparam int FLASH_HALF   = 4;

  localparam int M_INIT   = 0;
  localparam int M_NORMAL = 1;
  localparam int M_FAULT  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       red_in = 1'b1, yellow_in = 1'b0, green_in = 1'b0;
  logic       fault_clear = 1'b0;
  logic       red_out, yellow_out, green_out, fault;
  logic [1:0] fault_code;

  int errors = 0;
  int checks = 0;

  lamp_conflict_monitor #(
    .INIT_CYCLES (INIT_CYCLES),
    .FAULT_CYCLES(FAULT_CYCLES),
    .FLASH_HALF  (FLASH_HALF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .red_in     (red_in),
    .yellow_in  (yellow_in),
    .green_in   (green_in),
    .fault_clear(fault_clear),
    .red_out    (red_out),
    .yellow_out (yellow_out),
    .green_out  (green_out),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  // Behavioural reference: tracks elapsed edges in each mode and run lengths.
  int       m_mode = M_INIT;
  int       m_init_edges = 0;
  int       m_conf_run = 0;
  int       m_dark_run = 0;
  int       m_fault_age = 0;
  bit [2:0] m_out = 3'b100;
  bit [2:0] m_last = 3'b100;
  bit       m_fault = 1'b0;
  bit [1:0] m_code = 2'b00;

  function automatic bit pat_conflict(input bit [2:0] p);
    return p[0] && (p[2] || p[1]);
  endfunction

  function automatic bit pat_legal(input bit [2:0] p);
`ifdef LAMP_MON_DARK_DET_EN
    return !pat_conflict(p) && (p != 3'b000);
`else
    return !pat_conflict(p);
`endif
  endfunction

  task automatic model_enter_fault(input bit [1:0] cause);
    m_mode      = M_FAULT;
    m_fault     = 1'b1;
    m_code      = cause;
    m_fault_age = 0;
    m_out       = 3'b010;
  endtask

  task automatic model_step(input bit rst_n, input bit [2:0] p, input bit clr);
    if (!rst_n) begin
      m_mode = M_INIT; m_init_edges = 0; m_conf_run = 0; m_dark_run = 0;
      m_last = 3'b100; m_out = 3'b100; m_fault = 1'b0; m_code = 2'b00;
    end else if (m_mode == M_INIT) begin
      m_init_edges++;
      m_out = 3'b100;
      if (m_init_edges >= INIT_CYCLES) m_mode = M_NORMAL;
    end else if (m_mode == M_NORMAL) begin
      if (pat_legal(p)) begin
        m_out = p; m_last = p; m_conf_run = 0; m_dark_run = 0;
      end else if (pat_conflict(p)) begin
        m_dark_run = 0;
        if (m_conf_run < FAULT_CYCLES) m_conf_run++;
        m_out = m_last;
        if (m_conf_run == FAULT_CYCLES) model_enter_fault(2'b01);
      end else begin
        m_conf_run = 0;
        if (m_dark_run < FAULT_CYCLES) m_dark_run++;
        m_out = m_last;
        if (m_dark_run == FAULT_CYCLES) model_enter_fault(2'b10);
      end
    end else begin
      if (clr && pat_legal(p)) begin
        m_mode = M_INIT; m_init_edges = 0; m_conf_run = 0; m_dark_run = 0;
        m_last = 3'b100; m_out = 3'b100; m_fault = 1'b0; m_code = 2'b00;
      end else begin
        m_fault_age++;
        m_out = {1'b0, ((m_fault_age / FLASH_HALF) % 2) == 0, 1'b0};
      end
    end
  endtask

  task automatic check(input string name, input bit [2:0] eo, input bit ef, input bit [1:0] ec);
    checks++;
    if ({red_out, yellow_out, green_out} !== eo || fault !== ef || fault_code !== ec) begin
      errors++;
      $display("FAIL %s @%0t: got out=%b fault=%b code=%b, expected out=%b fault=%b code=%b",
               name, $time, {red_out, yellow_out, green_out}, fault, fault_code, eo, ef, ec);
    end
  endtask

  // Apply inputs, clock one edge, then compare against the model away from the edge.
  task automatic tick(input bit rst_n, input bit [2:0] p, input bit clr);
    reset = rst_n;
    {red_in, yellow_in, green_in} = p;
    fault_clear = clr;
    @(posedge clk);
    model_step(rst_n, p, clr);
    #1;
    check("model", m_out, m_fault, m_code);
  endtask

  typedef struct {
    bit       rst_n;
    bit [2:0] pat;
    bit       clr;
    bit [2:0] eo;
    bit       ef;
    bit [1:0] ec;
  } vec_t;

  vec_t tbl[40];

  function automatic vec_t mk(input bit rst_n, input bit [2:0] pat, input bit clr,
                              input bit [2:0] eo, input bit ef, input bit [1:0] ec);
    vec_t v;
    v.rst_n = rst_n; v.pat = pat; v.clr = clr; v.eo = eo; v.ef = ef; v.ec = ec;
    return v;
  endfunction

  initial begin
    // reset, INIT, legal pass-through
    tbl[0]  = mk(0, 3'b100, 0, 3'b100, 0, 2'b00);
    tbl[1]  = mk(0, 3'b100, 0, 3'b100, 0, 2'b00);
    tbl[2]  = mk(1, 3'b010, 0, 3'b100, 0, 2'b00);
    tbl[3]  = mk(1, 3'b010, 0, 3'b100, 0, 2'b00);
    tbl[4]  = mk(1, 3'b010, 0, 3'b100, 0, 2'b00);
    tbl[5]  = mk(1, 3'b010, 0, 3'b100, 0, 2'b00);
    tbl[6]  = mk(1, 3'b100, 0, 3'b100, 0, 2'b00);
    tbl[7]  = mk(1, 3'b110, 0, 3'b110, 0, 2'b00);
    tbl[8]  = mk(1, 3'b001, 0, 3'b001, 0, 2'b00);
    tbl[9]  = mk(1, 3'b010, 0, 3'b010, 0, 2'b00);
    tbl[10] = mk(1, 3'b001, 0, 3'b001, 0, 2'b00);
    // conflict trip, flash, clear handshake
    tbl[11] = mk(1, 3'b101, 0, 3'b001, 0, 2'b00);
    tbl[12] = mk(1, 3'b101, 0, 3'b001, 0, 2'b00);
    tbl[13] = mk(1, 3'b101, 0, 3'b010, 1, 2'b01);
    tbl[14] = mk(1, 3'b111, 1, 3'b010, 1, 2'b01);
    tbl[15] = mk(1, 3'b000, 0, 3'b010, 1, 2'b01);
    tbl[16] = mk(1, 3'b001, 0, 3'b010, 1, 2'b01);
    tbl[17] = mk(1, 3'b001, 0, 3'b000, 1, 2'b01);
    tbl[18] = mk(1, 3'b100, 1, 3'b100, 0, 2'b00);
    tbl[19] = mk(1, 3'b010, 0, 3'b100, 0, 2'b00);
    tbl[20] = mk(1, 3'b010, 0, 3'b100, 0, 2'b00);
    tbl[21] = mk(1, 3'b010, 0, 3'b100, 0, 2'b00);
    tbl[22] = mk(1, 3'b010, 0, 3'b100, 0, 2'b00);
    tbl[23] = mk(1, 3'b001, 0, 3'b001, 0, 2'b00);
    // glitch filter
    tbl[24] = mk(1, 3'b011, 0, 3'b001, 0, 2'b00);
    tbl[25] = mk(1, 3'b011, 0, 3'b001, 0, 2'b00);
    tbl[26] = mk(1, 3'b001, 0, 3'b001, 0, 2'b00);
    tbl[27] = mk(1, 3'b011, 0, 3'b001, 0, 2'b00);
    tbl[28] = mk(1, 3'b011, 0, 3'b001, 0, 2'b00);
    tbl[29] = mk(1, 3'b001, 0, 3'b001, 0, 2'b00);
    // trip again, then reset mid-fault restarts INIT
    tbl[30] = mk(1, 3'b111, 0, 3'b001, 0, 2'b00);
    tbl[31] = mk(1, 3'b111, 0, 3'b001, 0, 2'b00);
    tbl[32] = mk(1, 3'b111, 0, 3'b010, 1, 2'b01);
    tbl[33] = mk(1, 3'b111, 0, 3'b010, 1, 2'b01);
    tbl[34] = mk(0, 3'b111, 0, 3'b100, 0, 2'b00);
    tbl[35] = mk(1, 3'b001, 0, 3'b100, 0, 2'b00);
    tbl[36] = mk(1, 3'b001, 0, 3'b100, 0, 2'b00);
    tbl[37] = mk(1, 3'b001, 0, 3'b100, 0, 2'b00);
    tbl[38] = mk(1, 3'b001, 0, 3'b100, 0, 2'b00);
    tbl[39] = mk(1, 3'b001, 0, 3'b001, 0, 2'b00);

    for (int i = 0; i < 40; i++) begin
      tick(tbl[i].rst_n, tbl[i].pat, tbl[i].clr);
      check($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ef, tbl[i].ec);
    end

    // dark pattern held for FAULT_CYCLES samples
    tick(1, 3'b000, 0);
`ifdef LAMP_MON_DARK_DET_EN
    check("dark_hold", 3'b001, 0, 2'b00);
`else
    check("dark_pass", 3'b000, 0, 2'b00);
`endif
    tick(1, 3'b000, 0);
    tick(1, 3'b000, 0);
`ifdef LAMP_MON_DARK_DET_EN
    check("dark_trip", 3'b010, 1, 2'b10);
`else
    check("dark_no_trip", 3'b000, 0, 2'b00);
`endif

    // alternating conflict/dark never accumulates
    tick(1, 3'b001, 1);
    for (int i = 0; i < 8; i++) tick(1, (i % 2 == 0) ? 3'b101 : 3'b000, 0);

    // randomized run against the model
    tick(0, 3'b100, 0);
    for (int i = 0; i < 4000; i++) begin
      bit       rst_n;
      bit [2:0] p;
      bit       clr;
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) < 6) begin
        case ($urandom_range(0, 3))
          0: p = 3'b100;
          1: p = 3'b110;
          2: p = 3'b001;
          default: p = 3'b010;
        endcase
      end else begin
        p = 3'($urandom_range(0, 7));
      end
      clr = ($urandom_range(0, 3) == 0);
      tick(rst_n, p, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lamp_conflict_monitor.md
# lamp_conflict_monitor

Downstream safety stage between the traffic light controller's `red`/`yellow`/`green` outputs and the lamp drivers. It registers the requested lamp pattern and passes legal patterns through. Illegal patterns are masked by holding the last legal output. A persistent illegal pattern trips a latched fault that forces flashing yellow until an operator clear.

## Interface
Parameters:
- `INIT_CYCLES`, 4: cycles of solid red after reset or fault clear; 1..15.
- `FAULT_CYCLES`, 3: consecutive illegal samples that trip a fault; 1..15.
- `FLASH_HALF`, 4: cycles per half period of the fault flash; 1..15.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `red_in`, `yellow_in`, `green_in` in 1 each: requested lamp pattern from the controller.
- `fault_clear` in 1: operator clear; level-sampled each edge.
- `red_out`, `yellow_out`, `green_out` out 1 each: registered lamp drive.
- `fault` out 1: latched fault indicator.
- `fault_code` out 2: cause of fault. 00 none, 01 conflict, 10 dark.

## Operation
- Patterns are written {r,y,g}.
- Legal patterns: 100, 110, 001, 010.
- Conflict patterns: any with g=1 plus r or y, i.e. 101, 011, 111.
- Dark pattern: 000.
- States:
  - INIT: outputs 100. Inputs ignored. Both counters held at 0. After `INIT_CYCLES` edges in INIT, go to NORMAL.
  - NORMAL:
    - Legal input: copied to outputs, stored as last legal, both counters zeroed.
    - Conflict input: `conf_cnt`+1, `dark_cnt`=0, outputs hold last legal.
    - Dark input: `dark_cnt`+1, `conf_cnt`=0, outputs hold last legal.
    - Trip: if an increment makes a counter equal `FAULT_CYCLES`, move to FAULT at that edge. Set `fault`=1 and `fault_code` to the cause.
  - FAULT:
    - `red_out`=`green_out`=0.
    - `yellow_out`=flash phase. Phase is 1 on entry and toggles every `FLASH_HALF` cycles.
    - `fault` and `fault_code` stay latched. Inputs do not change the outputs.
    - Exit to INIT needs `fault_clear`=1 and a legal input sampled on the same edge. That edge sets `fault`=0, `fault_code`=00, outputs 100, and the last-legal register to 100.
- `fault_clear` in INIT or NORMAL is ignored.
- `fault_clear` with an illegal input in FAULT is ignored; the block stays in FAULT and the flash continues uninterrupted.
- Counters saturate at `FAULT_CYCLES`. They never wrap.

## Timing
- Reset (`reset`=0 at an edge):
  - Enter INIT.
  - `red_out`=1, `yellow_out`=0, `green_out`=0.
  - `fault`=0, `fault_code`=00.
  - Counters 0, flash phase 0, last-legal register 100.
- Reset takes priority over everything, including mid-FAULT and mid-INIT.
- Pass-through latency is one cycle: input sampled at edge k appears on the outputs after edge k.
- Trip latency: illegal on `FAULT_CYCLES` consecutive edges → `fault`=1 after the last of those edges, with `yellow_out`=1 from the same edge.
- One legal sample between illegal samples restarts counting from 0.
- Conflict and dark samples reset each other's counter. Alternating 101/000 never trips while `FAULT_CYCLES`>1.
- Flash: `yellow_out` high for `FLASH_HALF` cycles, then low for `FLASH_HALF` cycles, repeating.
- INIT duration: after reset is released, the first NORMAL pass-through is visible after edge `INIT_CYCLES`+1.

## Configuration
- `LAMP_MON_DARK_DET_EN`:
  - Defined: dark (000) is illegal and trips `fault_code`=10 as specified above.
  - Undefined:
    - 000 is treated as legal and passed through.
    - `dark_cnt` logic is removed.
    - `fault_code` never takes value 10.
    - 000 counts as legal for the `fault_clear` exit condition.

## Test plan
- Reset, then legal sequence (defaults):
  - Stimulus: `reset` low 2 cycles, release, drive 100,110,001,010.
  - Required: outputs 100 for 4 cycles, then each input echoed one cycle later; `fault`=0 throughout.
- Conflict trip:
  - Stimulus: in NORMAL with output 001, drive 101 for 3 cycles.
  - Required: outputs hold 001 for 2 cycles, then `fault`=1, `fault_code`=01, yellow flashes 4 on / 4 off, red and green 0.
- Glitch filter:
  - Stimulus: drive 011, 011, 001, 011, 011, 001.
  - Required: no fault; outputs never show g=1 together with r or y.
- Clear handshake:
  - Stimulus: in FAULT, assert `fault_clear` with input 111, then with input 100.
  - Required: first edge ignored and flash continues; second edge gives `fault`=0, `fault_code`=00, outputs 100 for 4 cycles, then pass-through.
- Dark detection:
  - Stimulus: drive 000 for 3 cycles.
  - Required with `LAMP_MON_DARK_DET_EN` defined: `fault_code`=10.
  - Required without it: outputs 000 after one cycle, no fault.
- Reset mid-fault:
  - Stimulus: assert `reset` while flashing.
  - Required: the next edge gives outputs 100, `fault`=0, and INIT restarts.
